// File: rtl/lpc_buffer_ctrl.sv
// lpc_buffer_ctrl: sequences ringbuffer pointers and capture RAM between
// the LPC sniffer (write side) and the UART framer (read side).
//
// Ports:
//   clk, reset (async active-low, deasserted synchronously inside)
//   in_valid/in_data          : decoded LPC record, one-cycle pulse
//   rb_write_addr/rb_read_addr: pointers from the ringbuffer
//   rb_empty/rb_full          : ringbuffer flags (registered view)
//   rb_write_done/rb_read_done: one-cycle pointer advance strobes
//   ram_we/ram_waddr/ram_wdata: RAM write port
//   ram_re/ram_raddr/ram_rdata: RAM read port, rdata one clk after re
//   out_valid/out_data/out_ready: record handshake to the UART framer
//   drop_count/overflow       : saturating drop counter, sticky flag
module lpc_buffer_ctrl #(
    parameter int BITS  = 7,
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [BITS-1:0]  rb_write_addr,
    input  logic [BITS-1:0]  rb_read_addr,
    input  logic             rb_empty,
    input  logic             rb_full,
    output logic             rb_write_done,
    output logic             rb_read_done,
    output logic             ram_we,
    output logic [BITS-1:0]  ram_waddr,
    output logic [WIDTH-1:0] ram_wdata,
    output logic             ram_re,
    output logic [BITS-1:0]  ram_raddr,
    input  logic [WIDTH-1:0] ram_rdata,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] drop_count,
    output logic             overflow
);

    typedef enum logic {
        W_IDLE,
        W_COMMIT
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_PRESENT,
        R_RELEASE
    } r_state_t;

    // Reset asserts at once but releases on a clock edge.
    logic [1:0] rst_sync;
    logic       rst_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n = rst_sync[1];

    // ---------------- write side ----------------
    w_state_t w_state;
    w_state_t w_next;
    logic     accept;
    logic     drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Combinational strobes are qualified by rst_n so that every
    // output reads zero as soon as reset is asserted.
    always_comb begin
        w_next        = w_state;
        accept        = 1'b0;
        drop          = 1'b0;
        rb_write_done = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                if (in_valid && rst_n) begin
                    if (!rb_full) begin
                        accept = 1'b1;
                        w_next = W_COMMIT;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            W_COMMIT: begin
                // Ringbuffer flags are stale here, so anything
                // arriving now cannot be placed safely.
                rb_write_done = 1'b1;
                drop          = in_valid;
                w_next        = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign ram_we    = accept;
    assign ram_waddr = accept ? rb_write_addr : '0;
    assign ram_wdata = accept ? in_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    // ---------------- read side ----------------
    r_state_t r_state;
    r_state_t r_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next       = r_state;
        ram_re       = 1'b0;
        out_valid    = 1'b0;
        rb_read_done = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                if (!rb_empty && rst_n) begin
                    ram_re = 1'b1;
                    r_next = R_FETCH;
                end
            end
            R_FETCH: begin
                r_next = R_PRESENT;
            end
            R_PRESENT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    r_next = R_RELEASE;
                end
            end
            R_RELEASE: begin
                rb_read_done = 1'b1;
                r_next       = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ram_raddr = ram_re ? rb_read_addr : '0;

    // RAM data lands during R_FETCH; hold it for the whole present phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else if (r_state == R_FETCH) begin
            out_data <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_lpc_buffer_ctrl.sv
// tb_lpc_buffer_ctrl: testbench for lpc_buffer_ctrl with a behavioural
// ringbuffer, capture RAM and an in-order record scoreboard.
module tb_lpc_buffer_ctrl;

    localparam int BITS  = 7;
    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic [BITS-1:0]  rb_write_addr;
    logic [BITS-1:0]  rb_read_addr;
    logic             rb_empty;
    logic             rb_full;
    logic             rb_write_done;
    logic             rb_read_done;
    logic             ram_we;
    logic [BITS-1:0]  ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic             ram_re;
    logic [BITS-1:0]  ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CNT_W-1:0] drop_count;
    logic             overflow;

    always #5 clk = ~clk;

    lpc_buffer_ctrl #(.BITS(BITS), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .rb_write_addr (rb_write_addr),
        .rb_read_addr  (rb_read_addr),
        .rb_empty      (rb_empty),
        .rb_full       (rb_full),
        .rb_write_done (rb_write_done),
        .rb_read_done  (rb_read_done),
        .ram_we        (ram_we),
        .ram_waddr     (ram_waddr),
        .ram_wdata     (ram_wdata),
        .ram_re        (ram_re),
        .ram_raddr     (ram_raddr),
        .ram_rdata     (ram_rdata),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_ready     (out_ready),
        .drop_count    (drop_count),
        .overflow      (overflow)
    );

    // Ringbuffer model: one slot kept free, so 2**BITS-1 records = full.
    logic [BITS-1:0]  wp;
    logic [BITS-1:0]  rp;
    logic [BITS-1:0]  wp1;
    logic [WIDTH-1:0] mem [0:(1<<BITS)-1];

    assign wp1           = wp + 1'b1;
    assign rb_write_addr = wp;
    assign rb_read_addr  = rp;
    assign rb_empty      = (wp == rp);
    assign rb_full       = (wp1 == rp);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (rb_write_done) wp <= wp + 1'b1;
            if (rb_read_done)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata <= mem[ram_raddr];
    end

    // Scoreboard and bookkeeping
    logic [WIDTH-1:0] q[$];
    int n_cmp = 0;
    int n_fail = 0;
    int we_cnt = 0;
    int wd_cnt = 0;
    int rd_cnt = 0;
    int pop_cnt = 0;
    int exp_drops = 0;
    logic prev_acc = 1'b0;
    logic [BITS-1:0] last_waddr = '0;

    typedef struct {
        logic             iv;
        logic [WIDTH-1:0] d;
        logic             we;
        logic             wd;
    } vec_t;

    vec_t tv[9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (ram_we) begin
            we_cnt++;
            last_waddr = ram_waddr;
        end
        if (rb_write_done) wd_cnt++;
        if (rb_read_done) rd_cnt++;
        if (out_valid && out_ready) begin
            n_cmp++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %0h want none", out_data);
            end else begin
                n_cmp--;
                check("sb_data", 64'(out_data), 64'(q.pop_front()));
                pop_cnt++;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        advance();
        prev_acc = 1'b0;
    endtask

    task automatic put(input logic [WIDTH-1:0] d);
        logic acc;
        acc = !rb_full && !prev_acc;
        in_valid = 1'b1;
        in_data  = d;
        if (acc) q.push_back(d);
        else exp_drops++;
        sample();
        advance();
        in_valid = 1'b0;
        prev_acc = acc;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        exp_drops = 0;
        repeat (3) tick();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) tick();
    endtask

    task automatic drain();
        int k;
        out_ready = 1'b1;
        for (k = 0; k < 2000; k++) begin
            if (q.size() == 0 && rb_empty && !out_valid) break;
            tick();
        end
        check("drain_bound", 64'(k < 2000), 64'(1));
    endtask

    task automatic wait_valid();
        int k;
        for (k = 0; k < 20; k++) begin
            if (out_valid) break;
            tick();
        end
        check("valid_bound", 64'(k < 20), 64'(1));
    endtask

    int b_we, b_wd, b_rd, b_pop;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        tv[0] = '{1'b1, 32'hA1, 1'b1, 1'b0};
        tv[1] = '{1'b1, 32'hA2, 1'b0, 1'b1};
        tv[2] = '{1'b1, 32'hA3, 1'b1, 1'b0};
        tv[3] = '{1'b0, 32'h0,  1'b0, 1'b1};
        tv[4] = '{1'b0, 32'h0,  1'b0, 1'b0};
        tv[5] = '{1'b1, 32'hA4, 1'b1, 1'b0};
        tv[6] = '{1'b0, 32'h0,  1'b0, 1'b1};
        tv[7] = '{1'b1, 32'hA5, 1'b1, 1'b0};
        tv[8] = '{1'b0, 32'h0,  1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", 64'({rb_write_done, rb_read_done, ram_we, ram_re,
                                  out_valid, overflow}), 64'(0));
        check("rst_data", 64'(out_data), 64'(0));
        check("rst_drop", 64'(drop_count), 64'(0));
        do_reset();

        // Single record round trip
        out_ready = 1'b1;
        b_we = we_cnt; b_wd = wd_cnt; b_rd = rd_cnt; b_pop = pop_cnt;
        put(32'hA5A5_0001);
        drain();
        check("t1_we", 64'(we_cnt - b_we), 64'(1));
        check("t1_waddr", 64'(last_waddr), 64'(0));
        check("t1_wdone", 64'(wd_cnt - b_wd), 64'(1));
        check("t1_rdone", 64'(rd_cnt - b_rd), 64'(1));
        check("t1_pop", 64'(pop_cnt - b_pop), 64'(1));
        check("t1_empty", 64'(rb_empty), 64'(1));

        // Table: back-to-back pulses, write pacing
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = tv[i].iv;
            in_data  = tv[i].d;
            if (tv[i].we) q.push_back(tv[i].d);
            if (tv[i].iv && !tv[i].we) exp_drops++;
            sample();
            check($sformatf("tv%0d_we", i), 64'(ram_we), 64'(tv[i].we));
            check($sformatf("tv%0d_wd", i), 64'(rb_write_done), 64'(tv[i].wd));
            if (tv[i].we)
                check($sformatf("tv%0d_wdata", i), 64'(ram_wdata), 64'(tv[i].d));
            advance();
        end
        in_valid = 1'b0;
        prev_acc = 1'b0;
        drain();
        check("t3_drop", 64'(drop_count), 64'(exp_drops));
        check("t3_drop1", 64'(drop_count), 64'(1));

        // Fill to full, then one more is dropped
        do_reset();
        out_ready = 1'b0;
        b_we = we_cnt;
        for (int i = 0; i < (1 << BITS) - 1; i++) begin
            put(32'hF000_0000 + i);
            tick();
        end
        check("t2_full", 64'(wd_cnt - b_wd >= 0 && rb_full), 64'(1));
        put(32'hDEAD_BEEF);
        tick();
        check("t2_we", 64'(we_cnt - b_we), 64'((1 << BITS) - 1));
        check("t2_drop", 64'(drop_count), 64'(1));
        check("t2_ovf", 64'(overflow), 64'(1));
        drain();

        // Stall in present phase
        do_reset();
        out_ready = 1'b0;
        put(32'h0BAD_CAFE);
        wait_valid();
        b_rd = rd_cnt;
        for (int i = 0; i < 10; i++) begin
            sample();
            check("t4_valid", 64'(out_valid), 64'(1));
            check("t4_data", 64'(out_data), 64'(32'h0BAD_CAFE));
            advance();
        end
        check("t4_no_rd", 64'(rd_cnt - b_rd), 64'(0));
        out_ready = 1'b1;
        repeat (4) tick();
        check("t4_rd_once", 64'(rd_cnt - b_rd), 64'(1));
        check("t4_valid_low", 64'(out_valid), 64'(0));

        // Long stream past pointer wrap
        do_reset();
        out_ready = 1'b1;
        b_pop = pop_cnt;
        for (int i = 0; i < 200; i++) begin
            put($urandom);
            tick();
        end
        drain();
        check("t5_pop", 64'(pop_cnt - b_pop), 64'(200));
        check("t5_drop", 64'(drop_count), 64'(0));
        check("t5_ovf", 64'(overflow), 64'(0));

        // Reset while presenting
        do_reset();
        out_ready = 1'b0;
        put(32'h1111_0001);
        put(32'h1111_0002);
        wait_valid();
        check("t6_pre_drop", 64'(drop_count), 64'(1));
        in_valid = 1'b1;
        in_data  = 32'h2222_0003;
        #2;
        reset = 1'b0;
        #1;
        check("t6_strb", 64'({rb_write_done, rb_read_done, ram_we, ram_re,
                              out_valid, overflow}), 64'(0));
        check("t6_addr", 64'({ram_waddr, ram_raddr}), 64'(0));
        check("t6_wdata", 64'(ram_wdata), 64'(0));
        check("t6_odata", 64'(out_data), 64'(0));
        check("t6_drop", 64'(drop_count), 64'(0));
        in_valid = 1'b0;
        b_wd = wd_cnt; b_rd = rd_cnt;
        do_reset();
        repeat (5) tick();
        check("t6_post_drop", 64'(drop_count), 64'(0));
        check("t6_post_strb", 64'((wd_cnt - b_wd) + (rd_cnt - b_rd)), 64'(0));
        check("t6_post_valid", 64'(out_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
